// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD block family: FSM state encodings and the
// pixel bit-expansion rule used to widen stored pixels onto the LCD bus.
package lcd_pkg;

    // Fetch FSM state encodings, kept as plain constants so legacy siblings
    // can compare against them without an enum type.
    localparam logic [1:0] LCD_IDLE    = 2'd0;
    localparam logic [1:0] LCD_FETCH   = 2'd1;
    localparam logic [1:0] LCD_CAPTURE = 2'd2;
    localparam logic [1:0] LCD_HOLD    = 2'd3;

    // Expansion rule: the pixel is replicated MSB-first across the output word
    // and the final copy is truncated. Returns, for a given output bit, the
    // pixel bit that drives it. With pix_bits == 1 every output bit maps to
    // pixel bit 0, giving all-ones / all-zeros.
    function automatic int unsigned lcd_expand_src(
        input int unsigned out_bit,
        input int unsigned data_w,
        input int unsigned pix_bits
    );
        int unsigned pos_from_msb;
        pos_from_msb = (data_w - 1) - out_bit;
        return (pix_bits - 1) - (pos_from_msb % pix_bits);
    endfunction

endpackage

// File: rtl/lcd_pix_expand.sv
// Combinational pixel expander: widens a PIX_BITS stored pixel to a DATA_W
// LCD word by MSB-first replication.
import lcd_pkg::*;

module lcd_pix_expand #(
    parameter int PIX_BITS = 1,
    parameter int DATA_W   = 8
) (
    input  logic [PIX_BITS-1:0] pix_i,
    output logic [DATA_W-1:0]   data_o
);

    // Each output bit is a fixed wire from one pixel bit; no logic involved.
    for (genvar i = 0; i < DATA_W; i++) begin : g_bit
        assign data_o[i] = pix_i[lcd_expand_src(i, DATA_W, PIX_BITS)];
    end

endmodule

// File: rtl/lcd_pixel_fetch.sv
// LCD pixel fetcher: during the active display region, reads one pixel from
// frame RAM every PHASES clocks, expands it to the LCD bus width and holds it
// on lcd_data until the next pixel is captured.
import lcd_pkg::*;

module lcd_pixel_fetch #(
    parameter int DATA_W    = 8,
    parameter int PIX_BITS  = 1,
    parameter int PHASES    = 3,
    parameter int ADDR_W    = 15,
    parameter int FRAME_PIX = 19200
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                frame_start,
    input  logic                h_active,
    input  logic                v_active,
    input  logic                invert,
    output logic                ram_rd,
    output logic [ADDR_W-1:0]   ram_addr,
    input  logic [PIX_BITS-1:0] ram_data,
    output logic [DATA_W-1:0]   lcd_data,
    output logic                lcd_valid,
    output logic                frame_done
);

    localparam int PH_W = $clog2(PHASES);
    localparam logic [PH_W-1:0]   PHASE_LAST = PH_W'(PHASES - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(FRAME_PIX - 1);

    logic                active;
    logic [1:0]          state_q,      state_d;
    logic [PH_W-1:0]     phase_q,      phase_d;
    logic [ADDR_W-1:0]   addr_q,       addr_d;
    logic [DATA_W-1:0]   lcd_data_q,   lcd_data_d;
    logic                lcd_valid_q,  lcd_valid_d;
    logic                frame_done_q, frame_done_d;
    logic                rd_strobe;

    logic                phase_last;
    logic [PH_W-1:0]     phase_nxt;
    logic                addr_last;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [DATA_W-1:0]   pix_exp;
    logic [DATA_W-1:0]   pix_val;

    assign active     = h_active && v_active;

    assign phase_last = (phase_q == PHASE_LAST);
    assign phase_nxt  = phase_last ? '0 : phase_q + 1'b1;
    assign addr_last  = (addr_q == ADDR_LAST);
    assign addr_nxt   = addr_last ? '0 : addr_q + 1'b1;

    lcd_pix_expand #(
        .PIX_BITS (PIX_BITS),
        .DATA_W   (DATA_W)
    ) u_expand (
        .pix_i  (ram_data),
        .data_o (pix_exp)
    );

    assign pix_val = invert ? ~pix_exp : pix_exp;

    // Next-state logic. frame_start has top priority, then loss of the active
    // region; only inside the active region does the FSM step. The phase
    // counter is held at 0 in IDLE so that FETCH always lands on phase 0.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        addr_d       = addr_q;
        lcd_data_d   = lcd_data_q;
        lcd_valid_d  = lcd_valid_q;
        frame_done_d = 1'b0;
        rd_strobe    = 1'b0;

        if (frame_start) begin
            state_d     = LCD_IDLE;
            phase_d     = '0;
            addr_d      = '0;
            lcd_data_d  = '0;
            lcd_valid_d = 1'b0;
        end else if (!active) begin
            // Address is kept so the next active region resumes where we left.
            state_d     = LCD_IDLE;
            phase_d     = '0;
            lcd_data_d  = '0;
            lcd_valid_d = 1'b0;
        end else begin
            case (state_q)
                LCD_IDLE: begin
                    state_d = LCD_FETCH;
                    phase_d = '0;
                end
                LCD_FETCH: begin
                    rd_strobe = 1'b1;
                    phase_d   = phase_nxt;
                    state_d   = LCD_CAPTURE;
                end
                LCD_CAPTURE: begin
                    lcd_data_d   = pix_val;
                    lcd_valid_d  = 1'b1;
                    addr_d       = addr_nxt;
                    frame_done_d = addr_last;
                    phase_d      = phase_nxt;
                    // With two phases CAPTURE is the last phase, so go
                    // straight back to FETCH.
                    state_d      = phase_last ? LCD_FETCH : LCD_HOLD;
                end
                LCD_HOLD: begin
                    phase_d = phase_nxt;
                    if (phase_last) begin
                        state_d = LCD_FETCH;
                    end
                end
                default: begin
                    state_d = LCD_IDLE;
                    phase_d = '0;
                end
            endcase
        end
    end

    // State registers with asynchronous reset to a quiet bus.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q      <= LCD_IDLE;
            phase_q      <= '0;
            addr_q       <= '0;
            lcd_data_q   <= '0;
            lcd_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            addr_q       <= addr_d;
            lcd_data_q   <= lcd_data_d;
            lcd_valid_q  <= lcd_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign ram_rd     = rd_strobe;
    assign ram_addr   = addr_q;
    assign lcd_data   = lcd_data_q;
    assign lcd_valid  = lcd_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_pixel_fetch.sv
// Directed bench for lcd_pixel_fetch: a default-parameter instance (1-bit
// pixels) and a 2-bit-pixel, 4-pixel-frame instance, each with a small RAM
// model answering reads one cycle later.
module tb_lcd_pixel_fetch;

    logic        clk = 1'b0;
    logic        rst;

    logic        h_a, v_a, fs_a, inv_a;
    logic        rd_a, done_a, valid_a;
    logic [14:0] addr_a;
    logic        rdata_a = 1'b0;
    logic [7:0]  lcd_a;

    logic        h_b, v_b, fs_b, inv_b;
    logic        rd_b, done_b, valid_b;
    logic [14:0] addr_b;
    logic [1:0]  rdata_b = 2'b00;
    logic [7:0]  lcd_b;

    logic        mem_a [16];
    logic [1:0]  mem_b [4];

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic        h, v, fs, inv;
        logic        rd;
        logic [14:0] addr;
        logic [7:0]  data;
        logic        valid, done;
        logic        lcd_dc;
    } vec_t;

    vec_t va [36];
    vec_t vb [17];

    lcd_pixel_fetch u_dut_a (
        .sys_clk     (clk),
        .sys_rst     (rst),
        .frame_start (fs_a),
        .h_active    (h_a),
        .v_active    (v_a),
        .invert      (inv_a),
        .ram_rd      (rd_a),
        .ram_addr    (addr_a),
        .ram_data    (rdata_a),
        .lcd_data    (lcd_a),
        .lcd_valid   (valid_a),
        .frame_done  (done_a)
    );

    lcd_pixel_fetch #(
        .PIX_BITS  (2),
        .FRAME_PIX (4)
    ) u_dut_b (
        .sys_clk     (clk),
        .sys_rst     (rst),
        .frame_start (fs_b),
        .h_active    (h_b),
        .v_active    (v_b),
        .invert      (inv_b),
        .ram_rd      (rd_b),
        .ram_addr    (addr_b),
        .ram_data    (rdata_b),
        .lcd_data    (lcd_b),
        .lcd_valid   (valid_b),
        .frame_done  (done_b)
    );

    always #5 clk = ~clk;

    // RAM models: data appears exactly one cycle after the read strobe.
    always @(posedge clk) begin
        if (rd_a) rdata_a <= mem_a[addr_a[3:0]];
        if (rd_b) rdata_b <= mem_b[addr_b[1:0]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic h, v, fs, inv, rd, input int addr,
                                input logic [7:0] data, input logic valid, done, dc);
        vec_t r;
        r.h = h; r.v = v; r.fs = fs; r.inv = inv; r.rd = rd;
        r.addr = 15'(addr); r.data = data; r.valid = valid; r.done = done;
        r.lcd_dc = dc;
        return r;
    endfunction

    initial begin
        // Pixel store: 1,0,1,0,0,1,0,1,1,0,...
        for (int i = 0; i < 16; i++) mem_a[i] = 1'b0;
        mem_a[0] = 1'b1; mem_a[2] = 1'b1; mem_a[5] = 1'b1; mem_a[7] = 1'b1; mem_a[8] = 1'b1;
        mem_b[0] = 2'b10; mem_b[1] = 2'b01; mem_b[2] = 2'b11; mem_b[3] = 2'b00;

        //            h  v  fs inv rd addr data  val done dc
        va[0]  = mk(1, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0);  // IDLE, first active cycle
        va[1]  = mk(1, 1, 0, 0, 1, 0, 8'h00, 0, 0, 0);  // FETCH 0
        va[2]  = mk(1, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0);  // CAPTURE 0
        va[3]  = mk(1, 1, 0, 0, 0, 1, 8'hFF, 1, 0, 0);
        va[4]  = mk(1, 1, 0, 0, 1, 1, 8'hFF, 1, 0, 0);  // FETCH 1
        va[5]  = mk(1, 1, 0, 0, 0, 1, 8'hFF, 1, 0, 0);
        va[6]  = mk(1, 1, 0, 0, 0, 2, 8'h00, 1, 0, 0);
        va[7]  = mk(1, 1, 0, 0, 1, 2, 8'h00, 1, 0, 0);  // FETCH 2
        va[8]  = mk(1, 1, 0, 0, 0, 2, 8'h00, 1, 0, 0);
        va[9]  = mk(1, 1, 0, 0, 0, 3, 8'hFF, 1, 0, 0);
        va[10] = mk(1, 1, 0, 0, 1, 3, 8'hFF, 1, 0, 0);
        va[11] = mk(1, 1, 0, 0, 0, 3, 8'hFF, 1, 0, 0);
        va[12] = mk(1, 1, 0, 0, 0, 4, 8'h00, 1, 0, 0);
        va[13] = mk(1, 1, 0, 0, 1, 4, 8'h00, 1, 0, 0);
        va[14] = mk(1, 1, 0, 0, 0, 4, 8'h00, 1, 0, 0);
        va[15] = mk(1, 1, 0, 0, 0, 5, 8'h00, 1, 0, 0);
        va[16] = mk(1, 1, 0, 0, 1, 5, 8'h00, 1, 0, 0);  // FETCH 5
        va[17] = mk(1, 1, 0, 0, 0, 5, 8'h00, 1, 0, 0);
        va[18] = mk(0, 1, 0, 0, 0, 6, 8'hFF, 1, 0, 0);  // HOLD of 5, h drops
        va[19] = mk(0, 1, 0, 0, 0, 6, 8'h00, 0, 0, 0);  // cleared
        va[20] = mk(0, 1, 0, 0, 0, 6, 8'h00, 0, 0, 0);
        va[21] = mk(1, 1, 0, 0, 0, 6, 8'h00, 0, 0, 0);  // reactivate
        va[22] = mk(1, 1, 0, 0, 1, 6, 8'h00, 0, 0, 0);  // resumes at 6
        va[23] = mk(1, 1, 0, 0, 0, 6, 8'h00, 0, 0, 0);
        va[24] = mk(1, 1, 0, 0, 0, 7, 8'h00, 1, 0, 0);
        va[25] = mk(1, 1, 0, 0, 1, 7, 8'h00, 1, 0, 0);
        va[26] = mk(1, 1, 0, 0, 0, 7, 8'h00, 1, 0, 0);
        va[27] = mk(1, 1, 0, 0, 0, 8, 8'hFF, 1, 0, 0);
        va[28] = mk(1, 1, 0, 0, 1, 8, 8'hFF, 1, 0, 0);
        va[29] = mk(1, 1, 0, 0, 0, 8, 8'hFF, 1, 0, 0);
        va[30] = mk(1, 1, 0, 0, 0, 9, 8'hFF, 1, 0, 0);
        va[31] = mk(1, 1, 1, 0, 0, 9, 8'hFF, 1, 0, 0);  // frame_start on FETCH 9
        va[32] = mk(1, 1, 0, 0, 0, 0, 8'h00, 0, 0, 1);
        va[33] = mk(1, 1, 0, 0, 1, 0, 8'h00, 0, 0, 1);  // next read at 0
        va[34] = mk(1, 1, 0, 0, 0, 0, 8'h00, 0, 0, 1);
        va[35] = mk(1, 1, 0, 0, 0, 1, 8'hFF, 1, 0, 0);

        vb[0]  = mk(1, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0);
        vb[1]  = mk(1, 1, 0, 0, 1, 0, 8'h00, 0, 0, 0);
        vb[2]  = mk(1, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0);
        vb[3]  = mk(1, 1, 0, 0, 0, 1, 8'hAA, 1, 0, 0);  // 2'b10 -> AA
        vb[4]  = mk(1, 1, 0, 0, 1, 1, 8'hAA, 1, 0, 0);
        vb[5]  = mk(1, 1, 0, 0, 0, 1, 8'hAA, 1, 0, 0);
        vb[6]  = mk(1, 1, 0, 0, 0, 2, 8'h55, 1, 0, 0);  // 2'b01 -> 55
        vb[7]  = mk(1, 1, 0, 0, 1, 2, 8'h55, 1, 0, 0);
        vb[8]  = mk(1, 1, 0, 0, 0, 2, 8'h55, 1, 0, 0);
        vb[9]  = mk(1, 1, 0, 0, 0, 3, 8'hFF, 1, 0, 0);  // 2'b11 -> FF
        vb[10] = mk(1, 1, 0, 0, 1, 3, 8'hFF, 1, 0, 0);
        vb[11] = mk(1, 1, 0, 0, 0, 3, 8'hFF, 1, 0, 0);  // capture of last pixel
        vb[12] = mk(1, 1, 0, 0, 0, 0, 8'h00, 1, 1, 0);  // wrap, frame_done
        vb[13] = mk(1, 1, 0, 0, 1, 0, 8'h00, 1, 0, 0);
        vb[14] = mk(1, 1, 0, 1, 0, 0, 8'h00, 1, 0, 0);  // invert at capture
        vb[15] = mk(1, 1, 0, 0, 0, 1, 8'h55, 1, 0, 0);  // ~AA
        vb[16] = mk(1, 1, 0, 0, 1, 1, 8'h55, 1, 0, 0);

        rst = 1'b1;
        h_a = 0; v_a = 0; fs_a = 0; inv_a = 0;
        h_b = 0; v_b = 0; fs_b = 0; inv_b = 0;
        repeat (3) @(negedge clk);
        check("reset ram_rd",    32'(rd_a),    32'd0);
        check("reset ram_addr",  32'(addr_a),  32'd0);
        check("reset lcd_data",  32'(lcd_a),   32'd0);
        check("reset lcd_valid", 32'(valid_a), 32'd0);
        check("reset frame_done",32'(done_a),  32'd0);
        rst = 1'b0;

        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            h_a = va[i].h; v_a = va[i].v; fs_a = va[i].fs; inv_a = va[i].inv;
            #1;
            check($sformatf("A%0d ram_rd", i),   32'(rd_a),   32'(va[i].rd));
            check($sformatf("A%0d ram_addr", i), 32'(addr_a), 32'(va[i].addr));
            check($sformatf("A%0d frame_done", i), 32'(done_a), 32'(va[i].done));
            if (!va[i].lcd_dc) begin
                check($sformatf("A%0d lcd_data", i),  32'(lcd_a),   32'(va[i].data));
                check($sformatf("A%0d lcd_valid", i), 32'(valid_a), 32'(va[i].valid));
            end
        end

        // Asynchronous reset in the middle of a HOLD, no clock edge in between.
        fs_a = 0;
        rst = 1'b1;
        #1;
        check("async rst ram_rd",     32'(rd_a),    32'd0);
        check("async rst ram_addr",   32'(addr_a),  32'd0);
        check("async rst lcd_data",   32'(lcd_a),   32'd0);
        check("async rst lcd_valid",  32'(valid_a), 32'd0);
        check("async rst frame_done", 32'(done_a),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        h_a = 1; v_a = 1;
        #1;
        check("post rst idle ram_rd", 32'(rd_a), 32'd0);
        @(negedge clk);
        #1;
        check("post rst first ram_rd",   32'(rd_a),   32'd1);
        check("post rst first ram_addr", 32'(addr_a), 32'd0);

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            h_a = 0;
            h_b = vb[i].h; v_b = vb[i].v; fs_b = vb[i].fs; inv_b = vb[i].inv;
            #1;
            check($sformatf("B%0d ram_rd", i),     32'(rd_b),    32'(vb[i].rd));
            check($sformatf("B%0d ram_addr", i),   32'(addr_b),  32'(vb[i].addr));
            check($sformatf("B%0d frame_done", i), 32'(done_b),  32'(vb[i].done));
            check($sformatf("B%0d lcd_data", i),   32'(lcd_b),   32'(vb[i].data));
            check($sformatf("B%0d lcd_valid", i),  32'(valid_b), 32'(vb[i].valid));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lcd_pixel_fetch.md
LCD_PIXEL_FETCH -- requirements
Module: lcd_pixel_fetch

Interface
REQ-001 SHALL have parameters: DATA_W, default 8, LCD bus width; PIX_BITS, default 1, stored bits per pixel (1..DATA_W); PHASES, default 3, sys_clk cycles per pixel (>=2); ADDR_W, default 15, RAM address width; FRAME_PIX, default 19200, pixels per frame (<=2**ADDR_W).
REQ-002 SHALL have ports (name, direction, width, meaning):
  sys_clk  in  1  sole clock, all state on rising edge.
  sys_rst  in  1  reset, asynchronous, active-high.
  frame_start  in  1  one-cycle pulse at start of frame.
  h_active  in  1  horizontal active region.
  v_active  in  1  vertical active region.
  invert  in  1  invert output pixel (sampled with pixel).
  ram_rd  out  1  one-cycle RAM read strobe.
  ram_addr  out  ADDR_W  pixel address for ram_rd.
  ram_data  in  PIX_BITS  RAM read data, valid exactly 1 cycle after ram_rd.
  lcd_data  out  DATA_W  expanded pixel to LCD.
  lcd_valid  out  1  lcd_data holds a current pixel.
  frame_done  out  1  one-cycle pulse when last pixel of frame fetched.

Function
REQ-003 active SHALL mean h_active && v_active, sampled each sys_clk.
REQ-004 Phase counter SHALL run 0..PHASES-1 and wrap to 0 while active; SHALL be forced to 0 whenever not active or on frame_start.
REQ-005 FSM states SHALL be IDLE, FETCH, CAPTURE, HOLD.
REQ-006 IDLE -> FETCH when active; any state -> IDLE when not active (same cycle decision, registered next edge).
REQ-007 FETCH (phase 0): ram_rd=1 for exactly one cycle, ram_addr = pixel address; next state CAPTURE.
REQ-008 CAPTURE (phase 1): register ram_data, expanded, into lcd_data; lcd_valid=1 from next cycle; address increments; next state HOLD, or FETCH if PHASES==2.
REQ-009 HOLD: lcd_data/lcd_valid held; -> FETCH when phase counter wraps to 0.
REQ-010 Expansion: PIX_BITS==1 -> all ones for 1, all zeros for 0; else pixel bits replicated MSB-first to fill DATA_W, truncating the final copy.
REQ-011 invert=1 SHALL bitwise-invert the expanded value before registering.
REQ-012 Address SHALL wrap FRAME_PIX-1 -> 0; frame_done pulses the cycle after capture of address FRAME_PIX-1.
REQ-013 frame_start SHALL clear address and phase to 0 and FSM to IDLE; it wins over a simultaneous increment or fetch.
REQ-014 Leaving active mid-pixel SHALL drop lcd_valid and clear lcd_data to 0 next cycle; the address SHALL be kept, so the next active region resumes at the next unfetched pixel.
REQ-015 ram_rd SHALL never be asserted outside FETCH; at most one read per PHASES cycles.

Reset
REQ-016 sys_rst SHALL asynchronously force: state IDLE, phase 0, ram_addr 0, ram_rd 0, lcd_data 0, lcd_valid 0, frame_done 0.
REQ-017 First FETCH after reset release SHALL occur on the first active cycle, reading address 0.

Structure
REQ-018 FSM state encodings and the expansion function SHALL live in shared package lcd_pkg, for reuse by sibling LCD blocks.
REQ-019 Bit expansion SHALL be one sub-module, lcd_pix_expand (combinational, parameterised on PIX_BITS/DATA_W); all else in lcd_pixel_fetch.
REQ-020 No latches; every combinational output SHALL have a default assignment.

Verification
REQ-021 Defaults, active held, RAM returns 1,0,1 -> ram_rd every 3 cycles at addr 0,1,2; lcd_data FF,00,FF, each held 3 cycles.
REQ-022 PIX_BITS=2, DATA_W=8, pixel 2'b10 -> lcd_data 8'hAA; invert=1 -> 8'h55.
REQ-023 FRAME_PIX=4, continuous active -> addresses 0,1,2,3,0; frame_done one pulse after capture of addr 3.
REQ-024 h_active drops during HOLD of addr 5 -> lcd_valid 0, lcd_data 0 next cycle; reactivate -> first read at addr 6.
REQ-025 frame_start coincident with FETCH of addr 9 -> no read of 9; next read at addr 0.
REQ-026 sys_rst asserted mid-HOLD, no clock edge -> all outputs 0 immediately; after release, first read at addr 0.
